// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signal bundle for the two-port memory arbiter.
// slave faces the arbiter; master faces requesters and the memory model.
interface mem_arbiter_if #(
  parameter int addr_size = 10,
  parameter int data_size = 8
) ();
  logic                 req0;
  logic                 req1;
  logic                 we0;
  logic                 we1;
  logic [addr_size-1:0] addr0;
  logic [addr_size-1:0] addr1;
  logic [data_size-1:0] wdata0;
  logic [data_size-1:0] wdata1;
  logic                 ack0;
  logic                 ack1;
  logic [data_size-1:0] rdata0;
  logic [data_size-1:0] rdata1;
  logic [addr_size-1:0] mem_addr;
  logic [data_size-1:0] mem_din;
  logic [data_size-1:0] mem_dout;
  logic                 mem_cs;
  logic                 mem_rd;
  logic                 mem_wt;
  logic                 busy;

  modport slave (
    input  req0, req1, we0, we1,
    input  addr0, addr1, wdata0, wdata1,
    input  mem_dout,
    output ack0, ack1, rdata0, rdata1,
    output mem_addr, mem_din,
    output mem_cs, mem_rd, mem_wt, busy
  );

  modport master (
    output req0, req1, we0, we1,
    output addr0, addr1, wdata0, wdata1,
    output mem_dout,
    input  ack0, ack1, rdata0, rdata1,
    input  mem_addr, mem_din,
    input  mem_cs, mem_rd, mem_wt, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two requesters access to one
// single-port memory, one transaction per IDLE/ACCESS/DONE pass.
module mem_arbiter #(
  parameter int addr_size = 10,
  parameter int data_size = 8
) (
  input logic        clk,
  input logic        rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic last_q, last_d;
  logic gid_q, gid_d;
  logic we_q, we_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic cs_q, cs_d;
  logic rd_q, rd_d;
  logic wt_q, wt_d;
  logic busy_q, busy_d;

  logic [addr_size-1:0] maddr_q, maddr_d;
  logic [data_size-1:0] mdin_q, mdin_d;
  logic [data_size-1:0] rdata0_q, rdata0_d;
  logic [data_size-1:0] rdata1_q, rdata1_d;

  logic                 sel;
  logic                 sel_we;
  logic [addr_size-1:0] sel_addr;
  logic [data_size-1:0] sel_wdata;

  // On a tie, the requester not granted last time wins.
  always_comb begin
    sel = bus.req1;
    if (bus.req0 && bus.req1) sel = ~last_q;
    sel_we    = sel ? bus.we1    : bus.we0;
    sel_addr  = sel ? bus.addr1  : bus.addr0;
    sel_wdata = sel ? bus.wdata1 : bus.wdata0;
  end

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    gid_d    = gid_q;
    we_d     = we_q;
    ack0_d   = ack0_q;
    ack1_d   = ack1_q;
    cs_d     = cs_q;
    rd_d     = rd_q;
    wt_d     = wt_q;
    busy_d   = busy_q;
    maddr_d  = maddr_q;
    mdin_d   = mdin_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = ACCESS;
          gid_d   = sel;
          last_d  = sel;
          we_d    = sel_we;
          maddr_d = sel_addr;
          if (sel_we) mdin_d = sel_wdata;
          cs_d    = 1'b1;
          wt_d    = sel_we;
          rd_d    = ~sel_we;
          busy_d  = 1'b1;
        end
      end
      ACCESS: begin
        state_d = DONE;
        cs_d    = 1'b0;
        rd_d    = 1'b0;
        wt_d    = 1'b0;
        ack0_d  = ~gid_q;
        ack1_d  = gid_q;
        if (!we_q) begin
          if (gid_q) rdata1_d = bus.mem_dout;
          else       rdata0_d = bus.mem_dout;
        end
      end
      DONE: begin
        state_d = IDLE;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      gid_q    <= 1'b0;
      we_q     <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      cs_q     <= 1'b0;
      rd_q     <= 1'b0;
      wt_q     <= 1'b0;
      busy_q   <= 1'b0;
      maddr_q  <= '0;
      mdin_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gid_q    <= gid_d;
      we_q     <= we_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      cs_q     <= cs_d;
      rd_q     <= rd_d;
      wt_q     <= wt_d;
      busy_q   <= busy_d;
      maddr_q  <= maddr_d;
      mdin_q   <= mdin_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.rdata0   = rdata0_q;
  assign bus.rdata1   = rdata1_q;
  assign bus.mem_addr = maddr_q;
  assign bus.mem_din  = mdin_q;
  assign bus.mem_cs   = cs_q;
  assign bus.mem_rd   = rd_q;
  assign bus.mem_wt   = wt_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: transaction-level model
// predicts grants, ack timing and read data.
module tb_mem_arbiter;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.addr_size(AW), .data_size(DW)) bus ();

  mem_arbiter #(.addr_size(AW), .data_size(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    bit            id;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            ack_edge;
  } txn_t;

  txn_t sb[$];

  logic [DW-1:0] tbmem [1<<AW];
  logic [DW-1:0] refmem[1<<AW];
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int next_free = 0;
  bit last = 1'b1;

  assign bus.mem_dout = tbmem[bus.mem_addr];

  always @(posedge clk) cyc++;

  always @(posedge clk)
    if (bus.mem_cs && bus.mem_wt) tbmem[bus.mem_addr] <= bus.mem_din;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: arbiter free from next_free onwards;
  // each grant occupies three edges and acks one edge after grant.
  task automatic model();
    int  e;
    bit  id;
    txn_t t;
    e = cyc + 1;
    if (rst_n && e >= next_free && (bus.req0 || bus.req1)) begin
      id = bus.req1;
      if (bus.req0 && bus.req1) id = !last;
      last = id;
      t.id    = id;
      t.we    = id ? bus.we1 : bus.we0;
      t.addr  = id ? bus.addr1 : bus.addr0;
      t.wdata = id ? bus.wdata1 : bus.wdata0;
      if (t.we) refmem[t.addr] = t.wdata;
      t.rdata = refmem[t.addr];
      t.ack_edge = e + 1;
      sb.push_back(t);
      next_free = e + 3;
    end
  endtask

  task automatic drv(bit r0, bit r1, bit w0, bit w1,
                     logic [AW-1:0] a0, logic [AW-1:0] a1,
                     logic [DW-1:0] d0, logic [DW-1:0] d1);
    @(posedge clk);
    #1;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.we0 = w0;
    bus.we1 = w1;
    bus.addr0 = a0;
    bus.addr1 = a1;
    bus.wdata0 = d0;
    bus.wdata1 = d1;
    model();
  endtask

  task automatic drv_rand(bit r0, bit r1);
    drv(r0, r1, 1'($urandom), 1'($urandom),
        AW'($urandom), AW'($urandom),
        DW'($urandom), DW'($urandom));
  endtask

  task automatic idle(int n);
    repeat (n) drv_rand(1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    txn_t t;
    bit   eb;
    if (rst_n) begin
      eb = 1'b0;
      if (sb.size() > 0)
        eb = (cyc >= sb[0].ack_edge - 1);
      chk("busy", 32'(bus.busy), 32'(eb));
      chk("rd_wt_excl", 32'(bus.mem_rd & bus.mem_wt), 0);
      chk("ack_excl", 32'(bus.ack0 & bus.ack1), 0);
      if (bus.mem_cs) begin
        if (sb.size() == 0) begin
          chk("cs_unexpected", 32'(bus.mem_cs), 0);
        end else begin
          chk("cs_cycle", cyc, sb[0].ack_edge - 1);
          chk("mem_addr", 32'(bus.mem_addr), 32'(sb[0].addr));
          chk("mem_wt", 32'(bus.mem_wt), 32'(sb[0].we));
          chk("mem_rd", 32'(bus.mem_rd), 32'(!sb[0].we));
          if (sb[0].we)
            chk("mem_din", 32'(bus.mem_din), 32'(sb[0].wdata));
        end
      end else begin
        chk("idle_ctl", 32'({bus.mem_rd, bus.mem_wt}), 0);
      end
      if (bus.ack0 || bus.ack1) begin
        if (sb.size() == 0) begin
          chk("ack_unexpected", 32'({bus.ack1, bus.ack0}), 0);
        end else begin
          t = sb.pop_front();
          chk("ack_cycle", cyc, t.ack_edge);
          chk("ack_id", 32'({bus.ack1, bus.ack0}),
              t.id ? 32'd2 : 32'd1);
          if (!t.we) begin
            if (t.id) exp_rd1 = t.rdata;
            else      exp_rd0 = t.rdata;
          end
        end
      end else if (sb.size() > 0) begin
        if (cyc >= sb[0].ack_edge) begin
          chk("ack_missing", 0, 1);
          void'(sb.pop_front());
        end
      end
      chk("rdata0", 32'(bus.rdata0), 32'(exp_rd0));
      chk("rdata1", 32'(bus.rdata1), 32'(exp_rd1));
    end
  end

  initial begin
    int w;
    for (int i = 0; i < (1 << AW); i++) begin
      tbmem[i]  = DW'(i) ^ 8'h3C;
      refmem[i] = DW'(i) ^ 8'h3C;
    end
    bus.req0 = 0; bus.req1 = 0;
    bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0;
    bus.wdata0 = '0; bus.wdata1 = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_cs", 32'(bus.mem_cs), 0);
    chk("rst_rdwt", 32'({bus.mem_rd, bus.mem_wt}), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_din", 32'(bus.mem_din), 0);
    chk("rst_rdata0", 32'(bus.rdata0), 0);
    chk("rst_rdata1", 32'(bus.rdata1), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    drv(1, 0, 1, 0, 10'd5, 10'd0, 8'hAA, 8'h00);
    idle(3);
    drv(1, 0, 0, 0, 10'd5, 10'd0, 8'h00, 8'h00);
    idle(3);
    chk("rd5", 32'(bus.rdata0), 32'h0AA);

    repeat (12) drv_rand(1'b1, 1'b1);
    idle(3);
    repeat (9) drv_rand(1'b0, 1'b1);
    idle(3);

    drv(1, 0, 0, 0, 10'd7, 10'd0, 8'h00, 8'h00);
    drv(1, 0, 0, 0, 10'd9, 10'd0, 8'h00, 8'h00);
    drv(1, 0, 0, 0, 10'd9, 10'd0, 8'h00, 8'h00);
    idle(3);

    drv(0, 1, 0, 1, 10'd0, 10'd1023, 8'h00, 8'h55);
    idle(3);
    drv(1, 0, 0, 0, 10'd1023, 10'd0, 8'h00, 8'h00);
    idle(3);
    chk("rd1023", 32'(bus.rdata0), 32'h055);

    repeat (300)
      drv_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(3);

    drv(1, 0, 0, 0, 10'd33, 10'd0, 8'h00, 8'h00);
    idle(1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_cs", 32'(bus.mem_cs), 0);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_ack", 32'({bus.ack1, bus.ack0}), 0);
    last = 1'b1;
    next_free = 0;
    exp_rd0 = '0;
    exp_rd1 = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) drv_rand(1'b1, 1'b1);
    repeat (20)
      drv_rand(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(4);

    w = 0;
    while (sb.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    chk("drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
